rvfi_multireg_check: RTL and testbench

RVFI_MULTIREG_CHECK -- requirements
Module: rvfi_multireg_check

---
 rtl/rvfi_multireg_check.sv | 103 ++++++++++
 tb/tb_rvfi_multireg_check.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_multireg_check.sv
// rvfi_multireg_check: shadows NTRACK architectural registers from RVFI writes and checks the rs1/rs2 reads of one instruction.
// Define RISCV_FORMAL_REGCHK_X0_EN to also flag nonzero x0 reads and freeze slots tracking x0.
module rvfi_multireg_check #(
  parameter int XLEN = 32,
  parameter int NRET = 1,
  parameter int CHANNEL_IDX = 0,
  parameter int NTRACK = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   check,
  input  logic [63:0]            insn_order,
  input  logic [5*NTRACK-1:0]    track_idx,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [64*NRET-1:0]     rvfi_order,
  input  logic [5*NRET-1:0]      rvfi_rd_addr,
  input  logic [XLEN*NRET-1:0]   rvfi_rd_wdata,
  input  logic [5*NRET-1:0]      rvfi_rs1_addr,
  input  logic [XLEN*NRET-1:0]   rvfi_rs1_rdata,
  input  logic [5*NRET-1:0]      rvfi_rs2_addr,
  input  logic [XLEN*NRET-1:0]   rvfi_rs2_rdata,
  output logic                   check_done,
  output logic                   check_fail,
  output logic [NTRACK-1:0]      fail_mask
);
  typedef enum logic {TRACK, DONE} state_t;
  state_t state;
  logic [XLEN-1:0] shadow [NTRACK];
  logic [63:0] shadow_order [NTRACK];
  logic [NTRACK-1:0] written;
  logic [XLEN-1:0] nxt_shadow [NTRACK];
  logic [63:0] nxt_order [NTRACK];
  logic [NTRACK-1:0] nxt_written, mismatch;
  logic x0_fail;
  logic [4:0] chk_rs1_addr, chk_rs2_addr;
  logic [XLEN-1:0] chk_rs1_rdata, chk_rs2_rdata;
  assign chk_rs1_addr  = rvfi_rs1_addr[5*CHANNEL_IDX +: 5];
  assign chk_rs2_addr  = rvfi_rs2_addr[5*CHANNEL_IDX +: 5];
  assign chk_rs1_rdata = rvfi_rs1_rdata[XLEN*CHANNEL_IDX +: XLEN];
  assign chk_rs2_rdata = rvfi_rs2_rdata[XLEN*CHANNEL_IDX +: XLEN];
`ifdef RISCV_FORMAL_REGCHK_X0_EN
  assign x0_fail = (chk_rs1_addr == 5'd0 && chk_rs1_rdata != '0) || (chk_rs2_addr == 5'd0 && chk_rs2_rdata != '0);
`else
  assign x0_fail = 1'b0;
`endif
  // Folding candidates in against the running shadow keeps the largest order, independent of channel position.
  always_comb begin
    nxt_written = written;
    mismatch = '0;
    for (int k = 0; k < NTRACK; k++) begin
      nxt_shadow[k] = shadow[k];
      nxt_order[k] = shadow_order[k];
      for (int c = 0; c < NRET; c++) begin
        if (state == TRACK && rvfi_valid[c] && !(check && c == CHANNEL_IDX)
            && rvfi_rd_addr[5*c +: 5] == track_idx[5*k +: 5]
`ifdef RISCV_FORMAL_REGCHK_X0_EN
            && track_idx[5*k +: 5] != 5'd0
`endif
            && rvfi_order[64*c +: 64] < insn_order
            && (!nxt_written[k] || rvfi_order[64*c +: 64] > nxt_order[k])) begin
          nxt_written[k] = 1'b1;
          nxt_order[k] = rvfi_order[64*c +: 64];
          nxt_shadow[k] = rvfi_rd_wdata[XLEN*c +: XLEN];
        end
      end
      mismatch[k] = nxt_written[k]
        && ((chk_rs1_addr == track_idx[5*k +: 5] && chk_rs1_rdata != nxt_shadow[k])
         || (chk_rs2_addr == track_idx[5*k +: 5] && chk_rs2_rdata != nxt_shadow[k]));
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= TRACK;
      written <= '0;
      check_done <= 1'b0;
      check_fail <= 1'b0;
      fail_mask <= '0;
      for (int k = 0; k < NTRACK; k++) begin
        shadow[k] <= '0;
        shadow_order[k] <= '0;
      end
    end else if (state == TRACK) begin
      shadow <= nxt_shadow;
      shadow_order <= nxt_order;
      written <= nxt_written;
      if (check) begin
        state <= DONE;
        check_done <= 1'b1;
        check_fail <= |mismatch || x0_fail;
        fail_mask <= mismatch;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && state == TRACK && check) begin
      assert (rvfi_valid[CHANNEL_IDX]);
      assume (rvfi_order[64*CHANNEL_IDX +: 64] == insn_order);
`ifdef FORMAL
      assert (!(|mismatch || x0_fail));
`endif
    end
  end
endmodule

// File: tb/tb_rvfi_multireg_check.sv
// tb_rvfi_multireg_check: directed scenarios plus randomized runs against a max-order write-log model.
module tb_rvfi_multireg_check;
  localparam int CI = 1;
  logic clock = 1'b0;
  logic reset, check;
  logic [63:0] insn_order;
  logic [9:0] track_idx;
  logic [1:0] rvfi_valid;
  logic [127:0] rvfi_order;
  logic [9:0] rvfi_rd_addr, rvfi_rs1_addr, rvfi_rs2_addr;
  logic [63:0] rvfi_rd_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
  logic check_done, check_fail;
  logic [1:0] fail_mask;
  int cmp = 0, bad = 0;
  typedef struct {logic [63:0] o; logic [4:0] rd; logic [31:0] d;} wr_t;
  wr_t q[$];

  rvfi_multireg_check #(.XLEN(32), .NRET(2), .CHANNEL_IDX(CI), .NTRACK(2)) dut (
    .clock(clock), .reset(reset), .check(check), .insn_order(insn_order), .track_idx(track_idx),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .check_done(check_done), .check_fail(check_fail), .fail_mask(fail_mask));

  always #5 clock = ~clock;

  task automatic idle();
    check = 0; rvfi_valid = 0; rvfi_order = 0; rvfi_rd_addr = 0; rvfi_rd_wdata = 0;
    rvfi_rs1_addr = 0; rvfi_rs1_rdata = 0; rvfi_rs2_addr = 0; rvfi_rs2_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clock); #1; idle();
  endtask

  task automatic do_reset();
    reset = 1; idle(); tick(); reset = 0;
  endtask

  task automatic wr(input int ch, input logic [63:0] o, input logic [4:0] rd, input logic [31:0] d);
    rvfi_valid[ch] = 1'b1; rvfi_order[64*ch +: 64] = o;
    rvfi_rd_addr[5*ch +: 5] = rd; rvfi_rd_wdata[32*ch +: 32] = d;
  endtask

  task automatic do_check(input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2, input logic [31:0] d2);
    check = 1; rvfi_valid[CI] = 1'b1; rvfi_order[64*CI +: 64] = insn_order;
    rvfi_rd_addr[5*CI +: 5] = 5'd1; rvfi_rd_wdata[32*CI +: 32] = 32'hdead;
    rvfi_rs1_addr[5*CI +: 5] = a1; rvfi_rs1_rdata[32*CI +: 32] = d1;
    rvfi_rs2_addr[5*CI +: 5] = a2; rvfi_rs2_rdata[32*CI +: 32] = d2;
    tick();
  endtask

  task automatic lookup(input logic [4:0] r, output logic f, output logic [31:0] v);
    logic [63:0] best = 0;
    f = 0; v = 0;
    foreach (q[i])
      if (q[i].rd == r && q[i].o < insn_order && (!f || q[i].o > best)) begin
        f = 1; best = q[i].o; v = q[i].d;
      end
  endtask

  task automatic test_reset();
    reset = 1; idle(); insn_order = 10; track_idx = {5'd7, 5'd5};
    tick(); tick();
    cmp += 3;
    if (check_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", check_done); end
    if (check_fail !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", check_fail); end
    if (fail_mask !== 2'b00) begin bad++; $display("FAIL reset_mask: got %b want 00", fail_mask); end
    reset = 0;
  endtask

  task automatic test_basic_pass();
    insn_order = 10; track_idx = {5'd7, 5'd5}; do_reset();
    wr(0, 3, 5, 32'hAA); tick();
    cmp++;
    if (check_done !== 1'b0) begin bad++; $display("FAIL basic_predone: got %b want 0", check_done); end
    do_check(5, 32'hAA, 0, 0);
    cmp += 3;
    if (check_done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", check_done); end
    if (check_fail !== 1'b0) begin bad++; $display("FAIL basic_fail: got %b want 0", check_fail); end
    if (fail_mask !== 2'b00) begin bad++; $display("FAIL basic_mask: got %b want 00", fail_mask); end
  endtask

  task automatic test_mismatch();
    insn_order = 10; track_idx = {5'd7, 5'd5}; do_reset();
    wr(0, 4, 7, 32'h2); tick();
    do_check(0, 0, 7, 32'h1);
    cmp += 3;
    if (check_done !== 1'b1) begin bad++; $display("FAIL mis_done: got %b want 1", check_done); end
    if (check_fail !== 1'b1) begin bad++; $display("FAIL mis_fail: got %b want 1", check_fail); end
    if (fail_mask !== 2'b10) begin bad++; $display("FAIL mis_mask: got %b want 10", fail_mask); end
  endtask

  task automatic test_frozen();
    wr(0, 5, 7, 32'h1); wr(1, 6, 5, 32'h9); tick();
    do_check(7, 32'h1, 5, 32'h9); tick();
    cmp += 2;
    if (check_fail !== 1'b1) begin bad++; $display("FAIL frozen_fail: got %b want 1", check_fail); end
    if (fail_mask !== 2'b10) begin bad++; $display("FAIL frozen_mask: got %b want 10", fail_mask); end
    insn_order = 10; do_reset();
    do_check(5, 32'h0, 7, 32'h0);
    wr(0, 2, 5, 32'h77); tick();
    do_check(5, 32'h1, 7, 32'h1);
    cmp += 2;
    if (check_fail !== 1'b0) begin bad++; $display("FAIL frozen_pass: got %b want 0", check_fail); end
    if (check_done !== 1'b1) begin bad++; $display("FAIL frozen_done: got %b want 1", check_done); end
  endtask

  task automatic test_same_cycle();
    insn_order = 10; track_idx = {5'd7, 5'd5}; do_reset();
    wr(1, 6, 5, 32'h11); wr(0, 5, 5, 32'h22); tick();
    do_check(5, 32'h11, 0, 0);
    cmp += 2;
    if (check_fail !== 1'b0) begin bad++; $display("FAIL same_cycle_fail: got %b want 0", check_fail); end
    if (check_done !== 1'b1) begin bad++; $display("FAIL same_cycle_done: got %b want 1", check_done); end
  endtask

  task automatic test_out_of_order();
    insn_order = 10; track_idx = {5'd7, 5'd5}; do_reset();
    wr(0, 8, 5, 32'h33); tick();
    wr(0, 7, 5, 32'h44); tick();
    wr(1, 12, 5, 32'h55); tick();
    do_check(5, 32'h33, 0, 0);
    cmp += 2;
    if (check_fail !== 1'b0) begin bad++; $display("FAIL ooo_fail: got %b want 0", check_fail); end
    if (fail_mask !== 2'b00) begin bad++; $display("FAIL ooo_mask: got %b want 00", fail_mask); end
  endtask

  task automatic test_reset_check();
    insn_order = 10; track_idx = {5'd7, 5'd5}; do_reset();
    wr(0, 3, 5, 32'hAA); tick();
    reset = 1; do_check(5, 32'hAA, 0, 0); reset = 0;
    cmp++;
    if (check_done !== 1'b0) begin bad++; $display("FAIL rst_chk_done: got %b want 0", check_done); end
    do_check(5, 32'hBEEF, 0, 0);
    cmp += 2;
    if (check_done !== 1'b1) begin bad++; $display("FAIL rst_chk_done2: got %b want 1", check_done); end
    if (check_fail !== 1'b0) begin bad++; $display("FAIL rst_chk_cleared: got %b want 0", check_fail); end
  endtask

`ifdef RISCV_FORMAL_REGCHK_X0_EN
  task automatic test_x0();
    insn_order = 10; track_idx = {5'd5, 5'd0}; do_reset();
    wr(0, 2, 0, 32'h9); tick();
    do_check(0, 32'h5, 0, 0);
    cmp += 2;
    if (check_fail !== 1'b1) begin bad++; $display("FAIL x0_fail: got %b want 1", check_fail); end
    if (fail_mask !== 2'b00) begin bad++; $display("FAIL x0_mask: got %b want 00", fail_mask); end
  endtask
`endif

  task automatic test_random();
    int perm[64];
    int p, tmp, j;
    logic f;
    logic [31:0] v, d1, d2;
    logic [4:0] a1, a2, t;
    logic [1:0] em;
    logic ef;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 64; i++) perm[i] = i;
      for (int i = 63; i > 0; i--) begin
        j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      p = 0;
      track_idx = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      insn_order = 64'($urandom_range(20, 40));
      do_reset(); q.delete();
      for (int cy = $urandom_range(1, 6); cy > 0; cy--) begin
        for (int ch = 0; ch < 2; ch++)
          if ($urandom_range(0, 1) == 1) begin
            v = $urandom; t = 5'($urandom_range(0, 3));
            wr(ch, 64'(perm[p]), t, v); q.push_back('{64'(perm[p]), t, v}); p++;
          end
        tick();
        if ($urandom_range(0, 15) == 0) begin do_reset(); q.delete(); end
      end
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom; t = 5'($urandom_range(0, 3));
        wr(0, 64'(perm[p]), t, v); q.push_back('{64'(perm[p]), t, v}); p++;
      end
      a1 = 5'($urandom_range(0, 3)); a2 = 5'($urandom_range(0, 3));
      lookup(a1, f, d1); if ($urandom_range(0, 2) == 0) d1 = $urandom;
      lookup(a2, f, d2); if ($urandom_range(0, 2) == 0) d2 = $urandom;
      for (int k = 0; k < 2; k++) begin
        t = track_idx[5*k +: 5];
        lookup(t, f, v);
`ifdef RISCV_FORMAL_REGCHK_X0_EN
        if (t == 5'd0) f = 0;
`endif
        em[k] = f && ((a1 == t && d1 != v) || (a2 == t && d2 != v));
      end
      ef = |em;
`ifdef RISCV_FORMAL_REGCHK_X0_EN
      ef = ef || (a1 == 5'd0 && d1 != 0) || (a2 == 5'd0 && d2 != 0);
`endif
      do_check(a1, d1, a2, d2);
      cmp += 3;
      if (check_done !== 1'b1) begin bad++; $display("FAIL rand_done it=%0d: got %b want 1", it, check_done); end
      if (check_fail !== ef) begin bad++; $display("FAIL rand_fail it=%0d: got %b want %b", it, check_fail, ef); end
      if (fail_mask !== em) begin bad++; $display("FAIL rand_mask it=%0d: got %b want %b", it, fail_mask, em); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_mismatch();
    test_frozen();
    test_same_cycle();
    test_out_of_order();
    test_reset_check();
`ifdef RISCV_FORMAL_REGCHK_X0_EN
    test_x0();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
